rpn_alu_sequencer: RTL and testbench
====================================

// Module: rpn_alu_sequencer
// PURPOSE
//  Sequences one STACK_BASED_ALU from a stream of postfix (RPN) tokens over a valid/ready interface.
//  - Pushes operands and runs ADD/MUL as ADD -> POP -> POP -> PUSH(result).
//  - Tracks stack depth; detects underflow, stack overflow and arithmetic overflow.
//  - Returns one result per expression on a valid/ready result port.
//  Replaces free-running ad-hoc sequencing between the equation parser and the ALU.
// PARAMETERS
//  WIDTH  32   ALU data width (signed)
//  DEPTH  512  ALU stack capacity in entries; depth counter is $clog2(DEPTH+1) bits
// PORTS
//  clk          in   1      clock, all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  tok_valid    in   1      token offered
//  tok_ready    out  1      token accepted when tok_valid && tok_ready
//  tok_type     in   2      00 NUM, 01 ADD, 10 MUL, 11 END
//  tok_value    in   WIDTH  operand for NUM (signed); ignored otherwise
//  res_valid    out  1      result/status available
//  res_ready    in   1      consumer takes result
//  res_data     out  WIDTH  expression value (0 on error)
//  res_err      out  3      {arith_ovf, stack_ovf, underflow}, sticky per expression
//  alu_data_in  out  WIDTH  ALU input_data
//  alu_opcode   out  3      100 ADD, 101 MUL, 110 PUSH, 111 POP, 000 NOP
//  alu_data_out in   WIDTH  ALU output_data; reflects the op issued in the previous cycle
//  alu_overflow in   1      ALU overflow; same timing as alu_data_out
// BEHAVIOUR
//  - Reset: every output is 0, alu_opcode=NOP, depth=0, state=ACCEPT.
//    This block does not clear ALU contents; the ALU shares rst.
//    Reset mid-expression abandons the expression and produces no res_valid.
//  - Every non-issuing state drives alu_opcode=NOP.
//  - ACCEPT (tok_ready=1):
//    - NUM, depth<DEPTH: issue PUSH tok_value; depth+1.
//    - NUM, depth==DEPTH: set stack_ovf -> DRAIN.
//    - ADD/MUL, depth>=2: issue ADD/MUL -> OPW.
//    - ADD/MUL, depth<2: set underflow -> DRAIN.
//    - END, depth==1: issue POP -> FINW.
//    - END, otherwise: set underflow -> DRAIN; END is marked already seen.
//  - Arithmetic ops, tok_ready=0 throughout:
//    - OPW: latch alu_data_out -> tmp; OR alu_overflow into arith_ovf; issue POP -> POP2.
//    - POP2: issue POP -> PSH.
//    - PSH: issue PUSH tmp; depth-1 -> ACCEPT.
//    - A binary op costs 4 cycles, token accept included; back-to-back NUM tokens sustain 1/cycle.
//  - FINW: latch alu_data_out -> res_data; depth=0 -> DONE.
//  - DRAIN: issue POP each cycle while depth>0, decrementing depth; at depth 0 go to
//    DISCARD, or to DONE if END was already seen.
//  - DISCARD: tok_ready=1; drop tokens until an END is accepted -> DONE.
//  - DONE: res_valid=1 with res_data and res_err stable until res_valid && res_ready.
//    Then clear res_err and res_valid -> ACCEPT. tok_ready=0 while in DONE.
//  - Arithmetic: wrap-around WIDTH-bit two's complement. arith_ovf alone does not abort
//    (default build); res_data is the wrapped value.
//  - The same-cycle res_ready handshake and the first new token are never overlapped;
//    there is a 1-cycle gap.
// CONFIGURATION
//  RPN_OVF_ABORT_EN
//    - Defined: alu_overflow seen in OPW sets arith_ovf and goes to DRAIN instead of POP2.
//      The wrapped result is never pushed; the expression is reported with res_data=0.
//    - Undefined: arith_ovf is a sticky warning only; evaluation continues.
// TESTING
//  1. NUM 3, NUM 4, ADD, END -> res_data=7, res_err=000; PUSH,PUSH,ADD,POP,POP,PUSH,POP on alu_opcode.
//  2. NUM 2, NUM 3, NUM 4, MUL, ADD, END -> res_data=14, res_err=000, depth 0 after DONE.
//  3. NUM 5, ADD, NUM 1, END -> underflow=1, one DRAIN POP, NUM 1 and END discarded, res_data=0.
//  4. DEPTH+1 NUM tokens then END -> stack_ovf=1, DEPTH POPs issued, res_data=0.
//  5. NUM 2^31-1, NUM 1, ADD, END, WIDTH=32 -> default: res_data=-2^31, arith_ovf=1;
//     with RPN_OVF_ABORT_EN: res_data=0, arith_ovf=1.
//  6. rst asserted in POP2, then NUM 9, END -> no res_valid for the first expression;
//     res_data=9, res_err=000.

Source files
------------

// File: rtl/rpn_alu_sequencer.sv
// Drives one stack-based ALU from a stream of postfix tokens and returns one result per expression.
// Optional build macro RPN_OVF_ABORT_EN: an ALU overflow abandons the expression instead of warning.
module rpn_alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tok_valid,
    output logic                         tok_ready,
    input  logic [1:0]                   tok_type,
    input  logic [WIDTH-1:0]             tok_value,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WIDTH-1:0]             res_data,
    output logic [2:0]                   res_err,
    output logic [WIDTH-1:0]             alu_data_in,
    output logic [2:0]                   alu_opcode,
    input  logic [WIDTH-1:0]             alu_data_out,
    input  logic                         alu_overflow,
    output logic [2:0]                   dbg_state,
    output logic [$clog2(DEPTH+1)-1:0]   dbg_depth
);
    // Handshakes: a token moves on a clock edge where tok_valid && tok_ready, a result
    // on an edge where res_valid && res_ready; ready never waits on valid.
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [1:0] T_NUM = 2'b00, T_ADD = 2'b01, T_MUL = 2'b10;
    localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b100, OP_MUL = 3'b101,
                           OP_PUSH = 3'b110, OP_POP = 3'b111;

    typedef enum logic [2:0] {
        S_ACCEPT  = 3'd0,
        S_OPW     = 3'd1,
        S_POP2    = 3'd2,
        S_PSH     = 3'd3,
        S_FINW    = 3'd4,
        S_DRAIN   = 3'd5,
        S_DISCARD = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t           state, state_n;
    logic [DW-1:0]    depth, depth_n;
    logic [WIDTH-1:0] tmp, tmp_n;
    logic [WIDTH-1:0] res_q, res_n;
    logic [2:0]       err_q, err_n;
    logic             end_seen, end_seen_n;
    logic [2:0]       op_c;
    logic [WIDTH-1:0] din_c;
    logic             trdy_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_ACCEPT;
            depth    <= '0;
            tmp      <= '0;
            res_q    <= '0;
            err_q    <= '0;
            end_seen <= 1'b0;
        end else begin
            state    <= state_n;
            depth    <= depth_n;
            tmp      <= tmp_n;
            res_q    <= res_n;
            err_q    <= err_n;
            end_seen <= end_seen_n;
        end
    end

    always_comb begin
        state_n    = state;
        depth_n    = depth;
        tmp_n      = tmp;
        res_n      = res_q;
        err_n      = err_q;
        end_seen_n = end_seen;
        op_c       = OP_NOP;
        din_c      = '0;
        trdy_c     = 1'b0;
        case (state)
            S_ACCEPT: begin
                trdy_c = 1'b1;
                if (tok_valid) begin
                    case (tok_type)
                        T_NUM: begin
                            if (depth < DEPTH_MAX) begin
                                op_c    = OP_PUSH;
                                din_c   = tok_value;
                                depth_n = depth + DW'(1);
                            end else begin
                                err_n[1] = 1'b1;
                                state_n  = S_DRAIN;
                            end
                        end
                        T_ADD, T_MUL: begin
                            if (depth >= DW'(2)) begin
                                op_c    = (tok_type == T_ADD) ? OP_ADD : OP_MUL;
                                state_n = S_OPW;
                            end else begin
                                err_n[0] = 1'b1;
                                state_n  = S_DRAIN;
                            end
                        end
                        default: begin
                            if (depth == DW'(1)) begin
                                op_c    = OP_POP;
                                state_n = S_FINW;
                            end else begin
                                err_n[0]   = 1'b1;
                                end_seen_n = 1'b1;
                                state_n    = S_DRAIN;
                            end
                        end
                    endcase
                end
            end
            S_OPW: begin
                // Operands stay on the ALU stack until both POPs; the result rides in tmp.
                tmp_n    = alu_data_out;
                err_n[2] = err_q[2] | alu_overflow;
`ifdef RPN_OVF_ABORT_EN
                if (alu_overflow) begin
                    state_n = S_DRAIN;
                end else begin
                    op_c    = OP_POP;
                    state_n = S_POP2;
                end
`else
                op_c    = OP_POP;
                state_n = S_POP2;
`endif
            end
            S_POP2: begin
                op_c    = OP_POP;
                state_n = S_PSH;
            end
            S_PSH: begin
                op_c    = OP_PUSH;
                din_c   = tmp;
                depth_n = depth - DW'(1);
                state_n = S_ACCEPT;
            end
            S_FINW: begin
                res_n   = alu_data_out;
                depth_n = '0;
                state_n = S_DONE;
            end
            S_DRAIN: begin
                if (depth != '0) begin
                    op_c    = OP_POP;
                    depth_n = depth - DW'(1);
                end else begin
                    state_n = end_seen ? S_DONE : S_DISCARD;
                end
            end
            S_DISCARD: begin
                trdy_c = 1'b1;
                if (tok_valid && (tok_type == 2'b11)) state_n = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    res_n      = '0;
                    err_n      = '0;
                    end_seen_n = 1'b0;
                    state_n    = S_ACCEPT;
                end
            end
            default: state_n = S_ACCEPT;
        endcase
    end

    assign tok_ready   = trdy_c & ~rst;
    assign alu_opcode  = rst ? OP_NOP : op_c;
    assign alu_data_in = rst ? '0 : din_c;
    assign res_valid   = (state == S_DONE) & ~rst;
    assign res_data    = res_q;
    assign res_err     = err_q;
    assign dbg_state   = state;
    assign dbg_depth   = depth;
endmodule

// File: tb/tb_rpn_alu_sequencer.sv
// Bench for rpn_alu_sequencer: behavioural stack ALU responder plus a queue-based RPN evaluator
// used as the reference for every expression result.
module tb_rpn_alu_sequencer;
    localparam int W  = 32;
    localparam int D  = 512;
    localparam int DW = $clog2(D + 1);
    localparam int BUDGET = 3000;

    localparam logic [1:0] T_NUM = 2'b00, T_ADD = 2'b01, T_MUL = 2'b10, T_END = 2'b11;
    localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b100, OP_MUL = 3'b101,
                           OP_PUSH = 3'b110, OP_POP = 3'b111;

    logic          clk, rst;
    logic          tok_valid, tok_ready;
    logic [1:0]    tok_type;
    logic [W-1:0]  tok_value;
    logic          res_valid, res_ready;
    logic [W-1:0]  res_data;
    logic [2:0]    res_err;
    logic [W-1:0]  alu_data_in, alu_data_out;
    logic [2:0]    alu_opcode;
    logic          alu_overflow;
    logic [2:0]    dbg_state;
    logic [DW-1:0] dbg_depth;

    int n_vec  = 0;
    int n_miss = 0;
    int n_pop  = 0;
    int n_res  = 0;
    int cyc    = 0;
    bit hung   = 0;

    logic [W+2:0]         exp_q[$];
    logic [2:0]           op_log[$];
    logic signed [W-1:0]  alu_stk[$];
    logic [1:0]           tt_q[$];
    logic [W-1:0]         tv_q[$];
    int                   acc_q[$];

    rpn_alu_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_type(tok_type), .tok_value(tok_value),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .alu_data_in(alu_data_in), .alu_opcode(alu_opcode),
        .alu_data_out(alu_data_out), .alu_overflow(alu_overflow),
        .dbg_state(dbg_state), .dbg_depth(dbg_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) cyc++;

    // Stack ALU responder: results of the op seen at an edge appear after that edge.
    always @(posedge clk) begin
        logic signed [W-1:0] a, b, t;
        longint full;
        if (res_valid && res_ready) n_res++;
        if (rst) begin
            alu_stk.delete();
            alu_data_out <= '0;
            alu_overflow <= 1'b0;
        end else begin
            case (alu_opcode)
                OP_PUSH: begin
                    alu_stk.push_back(alu_data_in);
                    alu_overflow <= 1'b0;
                end
                OP_POP: begin
                    if (alu_stk.size() > 0) alu_data_out <= alu_stk.pop_back();
                    n_pop++;
                    alu_overflow <= 1'b0;
                end
                OP_ADD, OP_MUL: begin
                    if (alu_stk.size() >= 2) begin
                        a = alu_stk[alu_stk.size()-1];
                        b = alu_stk[alu_stk.size()-2];
                        full = (alu_opcode == OP_ADD) ? longint'(a) + longint'(b)
                                                      : longint'(a) * longint'(b);
                        t = full[W-1:0];
                        alu_data_out <= t;
                        alu_overflow <= (longint'(t) != full);
                    end
                end
                default: alu_overflow <= 1'b0;
            endcase
            if (alu_opcode != OP_NOP) op_log.push_back(alu_opcode);
        end
    end

    // Reference: evaluate the token list up to its first END with an unbounded-precision stack.
    function automatic logic [W+2:0] ref_eval();
        longint stk[$];
        logic [2:0] err;
        logic [W-1:0] res;
        bit dead, fin;
        longint a, b, r, top;
        logic signed [W-1:0] wr;
        err = 3'b000; res = '0; dead = 0; fin = 0;
        for (int i = 0; i < tt_q.size() && !fin; i++) begin
            if (tt_q[i] == T_END) begin
                if (!dead) begin
                    if (stk.size() == 1) begin top = stk[0]; res = top[W-1:0]; end
                    else err[0] = 1'b1;
                end
                fin = 1;
            end else if (!dead) begin
                if (tt_q[i] == T_NUM) begin
                    if (stk.size() == D) begin err[1] = 1'b1; dead = 1; end
                    else begin wr = tv_q[i]; stk.push_back(longint'(wr)); end
                end else if (stk.size() < 2) begin
                    err[0] = 1'b1; dead = 1;
                end else begin
                    b = stk.pop_back();
                    a = stk.pop_back();
                    r = (tt_q[i] == T_ADD) ? a + b : a * b;
                    wr = r[W-1:0];
                    if (longint'(wr) != r) begin
                        err[2] = 1'b1;
`ifdef RPN_OVF_ABORT_EN
                        dead = 1;
`endif
                    end
                    stk.push_back(longint'(wr));
                end
            end
        end
        return {err, res};
    endfunction

    function automatic logic [W-1:0] rand_val();
        if ($urandom_range(0, 3) == 0) return W'($urandom);
        return W'($urandom_range(0, 40)) - W'(20);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tok_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        hung = 0;
    endtask

    task automatic send_tok(input logic [1:0] t, input logic [W-1:0] v, input int gap);
        int n;
        @(negedge clk);
        if (gap > 0) begin
            tok_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        tok_valid = 1'b1; tok_type = t; tok_value = v;
        n = 0;
        forever begin
            #1;
            if (tok_ready) begin
                @(posedge clk);
                acc_q.push_back(cyc);
                break;
            end
            @(negedge clk);
            n++;
            if (n > BUDGET) begin
                n_vec++; n_miss++;
                $display("FAIL tok_accept: tok_ready stayed %0b for %0d cycles, required 1", tok_ready, n);
                hung = 1;
                break;
            end
        end
    endtask

    task automatic get_result(input string name);
        int n, k;
        logic [W+2:0] exp, snap;
        bit stable;
        exp = exp_q.pop_front();
        n = 0;
        while (!res_valid && n < BUDGET) begin @(negedge clk); n++; end
        n_vec++;
        if (!res_valid) begin
            n_miss++;
            $display("FAIL %s_timeout: res_valid=0 after %0d cycles, required 1", name, n);
            do_reset();
            return;
        end
        snap = {res_err, res_data};
        stable = 1;
        k = $urandom_range(0, 3);
        repeat (k) begin
            @(negedge clk);
            if (!res_valid || ({res_err, res_data} !== snap)) stable = 0;
        end
        if (!stable) begin
            n_miss++;
            $display("FAIL %s_hold: result changed during stall (first err=%b data=%h)", name, snap[W+2:W], snap[W-1:0]);
        end
        n_vec++;
        if ({res_err, res_data} !== exp) begin
            n_miss++;
            $display("FAIL %s_result: got err=%b data=%h, required err=%b data=%h",
                     name, res_err, res_data, exp[W+2:W], exp[W-1:0]);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_vec++;
        if (res_valid !== 1'b0 || dbg_depth !== '0 || res_err !== 3'b000) begin
            n_miss++;
            $display("FAIL %s_after: res_valid=%b depth=%0d err=%b, required 0 0 000", name, res_valid, dbg_depth, res_err);
        end
    endtask

    task automatic run_expr(input string name, input int max_gap);
        acc_q.delete();
        exp_q.push_back(ref_eval());
        for (int i = 0; i < tt_q.size() && !hung; i++) send_tok(tt_q[i], tv_q[i], $urandom_range(0, max_gap));
        @(negedge clk);
        tok_valid = 1'b0;
        get_result(name);
    endtask

    task automatic add_tok(input logic [1:0] t, input logic [W-1:0] v);
        tt_q.push_back(t);
        tv_q.push_back(v);
    endtask

    task automatic test_reset();
        rst = 1'b1; tok_valid = 1'b1; tok_type = T_NUM; tok_value = 32'h1234; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (tok_ready !== 1'b0 || res_valid !== 1'b0 || alu_opcode !== OP_NOP || alu_data_in !== '0 ||
            res_data !== '0 || res_err !== 3'b000) begin
            n_miss++;
            $display("FAIL reset_outputs: rdy=%b vld=%b op=%b din=%h data=%h err=%b, required all 0",
                     tok_ready, res_valid, alu_opcode, alu_data_in, res_data, res_err);
        end
        tok_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (tok_ready !== 1'b1 || dbg_depth !== '0 || alu_opcode !== OP_NOP) begin
            n_miss++;
            $display("FAIL reset_idle: rdy=%b depth=%0d op=%b, required 1 0 000", tok_ready, dbg_depth, alu_opcode);
        end
    endtask

    task automatic test_add_basic();
        logic [2:0] exp_ops[7];
        bit ok;
        exp_ops = '{OP_PUSH, OP_PUSH, OP_ADD, OP_POP, OP_POP, OP_PUSH, OP_POP};
        tt_q.delete(); tv_q.delete();
        add_tok(T_NUM, 3); add_tok(T_NUM, 4); add_tok(T_ADD, 0); add_tok(T_END, 0);
        op_log.delete();
        run_expr("add_basic", 1);
        ok = (op_log.size() == 7);
        if (ok) foreach (exp_ops[i]) if (op_log[i] !== exp_ops[i]) ok = 0;
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL add_opcodes: got %0d ops (first %b), required PUSH,PUSH,ADD,POP,POP,PUSH,POP",
                     op_log.size(), (op_log.size() > 0) ? op_log[0] : 3'b000);
        end
    endtask

    task automatic test_nested();
        tt_q.delete(); tv_q.delete();
        add_tok(T_NUM, 2); add_tok(T_NUM, 3); add_tok(T_NUM, 4);
        add_tok(T_MUL, 0); add_tok(T_ADD, 0); add_tok(T_END, 0);
        run_expr("nested", 2);
    endtask

    task automatic test_underflow_discard();
        tt_q.delete(); tv_q.delete();
        add_tok(T_NUM, 5); add_tok(T_ADD, 0); add_tok(T_NUM, 1); add_tok(T_END, 0);
        op_log.delete();
        n_pop = 0;
        run_expr("underflow", 1);
        n_vec++;
        if (n_pop != 1 || op_log.size() != 2) begin
            n_miss++;
            $display("FAIL underflow_pops: got %0d pops %0d ops, required 1 pop 2 ops", n_pop, op_log.size());
        end
    endtask

    task automatic test_stack_overflow();
        tt_q.delete(); tv_q.delete();
        for (int i = 0; i <= D; i++) add_tok(T_NUM, rand_val());
        add_tok(T_END, 0);
        n_pop = 0;
        run_expr("stack_ovf", 0);
        n_vec++;
        if (n_pop != D) begin
            n_miss++;
            $display("FAIL stack_ovf_pops: got %0d pops, required %0d", n_pop, D);
        end
    endtask

    task automatic test_arith_overflow();
        tt_q.delete(); tv_q.delete();
        add_tok(T_NUM, 32'h7fff_ffff); add_tok(T_NUM, 1); add_tok(T_ADD, 0); add_tok(T_END, 0);
        run_expr("arith_ovf_add", 1);
        tt_q.delete(); tv_q.delete();
        add_tok(T_NUM, 32'h0001_0000); add_tok(T_NUM, 32'h0001_0000); add_tok(T_MUL, 0);
        add_tok(T_NUM, 7); add_tok(T_ADD, 0); add_tok(T_END, 0);
        run_expr("arith_ovf_mul", 1);
    endtask

    task automatic test_reset_mid_op();
        int res0, n;
        res0 = n_res;
        acc_q.delete();
        send_tok(T_NUM, 3, 0);
        send_tok(T_NUM, 4, 0);
        send_tok(T_ADD, 0, 0);
        @(negedge clk);
        tok_valid = 1'b0;
        n = 0;
        while (dbg_state !== 3'd2 && n < 20) begin @(negedge clk); n++; end
        n_vec++;
        if (dbg_state !== 3'd2) begin
            n_miss++;
            $display("FAIL midrst_reach: state=%0d, required 2 within 20 cycles", dbg_state);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b0 || dbg_depth !== '0) begin
            n_miss++;
            $display("FAIL midrst_state: res_valid=%b depth=%0d, required 0 0", res_valid, dbg_depth);
        end
        tt_q.delete(); tv_q.delete();
        add_tok(T_NUM, 9); add_tok(T_END, 0);
        run_expr("midrst_next", 1);
        n_vec++;
        if (n_res != res0 + 1) begin
            n_miss++;
            $display("FAIL midrst_count: got %0d results, required %0d", n_res - res0, 1);
        end
    endtask

    task automatic test_back_to_back();
        tt_q.delete(); tv_q.delete();
        for (int i = 0; i < 8; i++) add_tok(T_NUM, rand_val());
        for (int i = 0; i < 7; i++) add_tok(($urandom_range(0, 1) != 0) ? T_ADD : T_MUL, 0);
        add_tok(T_END, 0);
        run_expr("b2b", 0);
        n_vec++;
        if (acc_q.size() != 16) begin
            n_miss++;
            $display("FAIL b2b_count: got %0d accepts, required 16", acc_q.size());
        end else begin
            if (acc_q[7] - acc_q[0] != 7) begin
                n_miss++;
                $display("FAIL b2b_num_rate: 8 NUMs took %0d cycles, required 7", acc_q[7] - acc_q[0]);
            end
            n_vec++;
            if (acc_q[14] - acc_q[8] != 24 || acc_q[15] - acc_q[14] != 4) begin
                n_miss++;
                $display("FAIL b2b_op_rate: op span %0d, end gap %0d, required 24 4",
                         acc_q[14] - acc_q[8], acc_q[15] - acc_q[14]);
            end
        end
    endtask

    task automatic test_random();
        int nums, d, pos, k;
        for (int e = 0; e < 40; e++) begin
            tt_q.delete(); tv_q.delete();
            nums = $urandom_range(1, 6);
            d = 0;
            while (nums > 0 || d > 1) begin
                if (nums > 0 && (d < 2 || $urandom_range(0, 1) == 0)) begin
                    add_tok(T_NUM, rand_val()); nums--; d++;
                end else begin
                    add_tok(($urandom_range(0, 1) != 0) ? T_MUL : T_ADD, 0); d--;
                end
            end
            add_tok(T_END, 0);
            if ($urandom_range(0, 3) == 0) begin
                pos = $urandom_range(0, tt_q.size() - 1);
                tt_q.insert(pos, 2'($urandom_range(0, 3)));
                tv_q.insert(pos, rand_val());
            end
            k = 0;
            while (tt_q[k] != T_END) k++;
            while (tt_q.size() > k + 1) begin void'(tt_q.pop_back()); void'(tv_q.pop_back()); end
            run_expr("random", 2);
        end
    endtask

    initial begin
        tok_valid = 1'b0; tok_type = T_NUM; tok_value = '0; res_ready = 1'b0; rst = 1'b1;
        test_reset();
        test_add_basic();
        test_nested();
        test_underflow_discard();
        test_stack_overflow();
        test_arith_overflow();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
